// File: rtl/pipe_mem_wb.sv
// EX/MEM and MEM/WB pipeline registers with write-back select
// and a retired-instruction counter.
package rv32_pkg;
  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } WBSel_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2data;
    logic        RegWEn;
    logic        MemRW;
    WBSel_t      WBSel;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic        RegWEn;
    logic [31:0] wb_data;
  } mem_wb_t;
endpackage

module pipe_mem_wb
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_MEM,
  input  logic             flush_MEM,
  input  logic             valid_EX,
  input  logic [31:0]      inst_EX,
  input  logic [31:0]      pc_EX,
  input  logic [31:0]      alu_EX,
  input  logic [31:0]      rs2data_EX,
  input  logic             RegWEn_EX,
  input  logic             MemRW_EX,
  input  WBSel_t           WBSel_EX,
  input  logic [31:0]      dmem_rdata,
  output logic             valid_MEM,
  output logic [31:0]      inst_MEM,
  output logic [31:0]      pc_MEM,
  output logic [31:0]      alu_MEM,
  output logic [31:0]      rs2data_MEM,
  output logic             RegWEn_MEM,
  output logic             MemRW_MEM,
  output WBSel_t           WBSel_MEM,
  output logic             valid_WB,
  output logic [31:0]      inst_WB,
  output logic             RegWEn_WB,
  output logic [31:0]      wb_data_WB,
  output logic [CNT_W-1:0] retire_count
);

  ex_mem_t     em_q, em_d, em_bub, em_ld;
  mem_wb_t     wb_q, wb_d, wb_bub;
  logic [31:0] wb_sel;

  always_comb begin
    wb_sel = '0;
    unique case (em_q.WBSel)
      WB_ALU:  wb_sel = em_q.alu;
      WB_MEM:  wb_sel = dmem_rdata;
      WB_PC4:  wb_sel = em_q.pc + 32'd4;
      default: wb_sel = '0;
    endcase
  end

  always_comb begin
    em_bub       = '0;
    em_bub.inst  = NOP_INST;
    em_bub.WBSel = WB_ALU;

    em_ld         = '0;
    em_ld.valid   = valid_EX;
    em_ld.inst    = inst_EX;
    em_ld.pc      = pc_EX;
    em_ld.alu     = alu_EX;
    em_ld.rs2data = rs2data_EX;
    em_ld.RegWEn  = valid_EX & RegWEn_EX;
    em_ld.MemRW   = valid_EX & MemRW_EX;
    em_ld.WBSel   = WBSel_EX;

    em_d = em_ld;
    priority case (1'b1)
      rst:       em_d = em_bub;
      flush_MEM: em_d = em_bub;
      stall_MEM: em_d = em_q;
      default:   em_d = em_ld;
    endcase
  end

  // A stalled MEM stage must not retire, so WB takes a bubble.
  always_comb begin
    wb_bub      = '0;
    wb_bub.inst = NOP_INST;

    wb_d         = '0;
    wb_d.valid   = em_q.valid;
    wb_d.inst    = em_q.inst;
    wb_d.RegWEn  = em_q.RegWEn;
    wb_d.wb_data = wb_sel;
    if (rst || stall_MEM)
      wb_d = wb_bub;
  end

  always_ff @(posedge clk) begin
    em_q <= em_d;
    wb_q <= wb_d;
    if (rst)
      retire_count <= '0;
    else if (wb_q.valid)
      retire_count <= retire_count + CNT_W'(1);
  end

  assign valid_MEM   = em_q.valid;
  assign inst_MEM    = em_q.inst;
  assign pc_MEM      = em_q.pc;
  assign alu_MEM     = em_q.alu;
  assign rs2data_MEM = em_q.rs2data;
  assign RegWEn_MEM  = em_q.RegWEn;
  assign MemRW_MEM   = em_q.MemRW;
  assign WBSel_MEM   = em_q.WBSel;

  assign valid_WB    = wb_q.valid;
  assign inst_WB     = wb_q.inst;
  assign RegWEn_WB   = wb_q.RegWEn;
  assign wb_data_WB  = wb_q.wb_data;

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Bench for pipe_mem_wb: vector table, corner sequences,
// and random traffic against an instruction-level model.
module tb_pipe_mem_wb;
  import rv32_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0020_81B3;
  localparam logic [31:0] LW  = 32'h0000_A183;
  localparam logic [31:0] SW  = 32'h0020_A023;
  localparam logic [31:0] JAL = 32'h0080_00EF;

  logic        clk = 1'b0;
  logic        rst, stall_MEM, flush_MEM, valid_EX;
  logic [31:0] inst_EX, pc_EX, alu_EX, rs2data_EX;
  logic        RegWEn_EX, MemRW_EX;
  WBSel_t      WBSel_EX;
  logic [31:0] dmem_rdata;
  logic        valid_MEM, RegWEn_MEM, MemRW_MEM;
  logic [31:0] inst_MEM, pc_MEM, alu_MEM, rs2data_MEM;
  WBSel_t      WBSel_MEM;
  logic        valid_WB, RegWEn_WB;
  logic [31:0] inst_WB, wb_data_WB, retire_count;

  pipe_mem_wb dut (
    .clk(clk), .rst(rst),
    .stall_MEM(stall_MEM), .flush_MEM(flush_MEM),
    .valid_EX(valid_EX), .inst_EX(inst_EX),
    .pc_EX(pc_EX), .alu_EX(alu_EX),
    .rs2data_EX(rs2data_EX), .RegWEn_EX(RegWEn_EX),
    .MemRW_EX(MemRW_EX), .WBSel_EX(WBSel_EX),
    .dmem_rdata(dmem_rdata),
    .valid_MEM(valid_MEM), .inst_MEM(inst_MEM),
    .pc_MEM(pc_MEM), .alu_MEM(alu_MEM),
    .rs2data_MEM(rs2data_MEM), .RegWEn_MEM(RegWEn_MEM),
    .MemRW_MEM(MemRW_MEM), .WBSel_MEM(WBSel_MEM),
    .valid_WB(valid_WB), .inst_WB(inst_WB),
    .RegWEn_WB(RegWEn_WB), .wb_data_WB(wb_data_WB),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instruction-level model: what sits in MEM, what sits in WB.
  typedef struct {
    bit v; bit [31:0] inst, pc, alu, rs2;
    bit rw, mw; bit [1:0] sel;
  } ins_t;
  typedef struct { bit v; bit [31:0] inst; bit rw; bit [31:0] d; } wbr_t;

  ins_t        m_mem;
  wbr_t        m_wb;
  logic [31:0] m_cnt;

  function automatic ins_t ins_bub();
    ins_t b;
    b = '{0, NOP, 0, 0, 0, 0, 0, 2'd1};
    return b;
  endfunction

  function automatic wbr_t wb_bub();
    wbr_t b;
    b = '{0, NOP, 0, 0};
    return b;
  endfunction

  function automatic logic [31:0] wbval(ins_t i, logic [31:0] rd);
    if (i.sel == 2'(WB_ALU)) return i.alu;
    if (i.sel == 2'(WB_MEM)) return rd;
    if (i.sel == 2'(WB_PC4)) return 32'(64'(i.pc) + 64'd4);
    return 32'd0;
  endfunction

  task automatic model_edge();
    ins_t ld;
    wbr_t nw;
    ld = '{valid_EX, inst_EX, pc_EX, alu_EX, rs2data_EX,
           RegWEn_EX && valid_EX, MemRW_EX && valid_EX, 2'(WBSel_EX)};
    if (rst || stall_MEM) nw = wb_bub();
    else nw = '{m_mem.v, m_mem.inst, m_mem.rw, wbval(m_mem, dmem_rdata)};
    m_cnt = rst ? 32'd0 : m_cnt + (m_wb.v ? 32'd1 : 32'd0);
    if (rst || flush_MEM) m_mem = ins_bub();
    else if (!stall_MEM) m_mem = ld;
    m_wb = nw;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_MEM", 32'(valid_MEM), 32'(m_mem.v));
    chk("inst_MEM", inst_MEM, m_mem.inst);
    chk("pc_MEM", pc_MEM, m_mem.pc);
    chk("alu_MEM", alu_MEM, m_mem.alu);
    chk("rs2data_MEM", rs2data_MEM, m_mem.rs2);
    chk("RegWEn_MEM", 32'(RegWEn_MEM), 32'(m_mem.rw));
    chk("MemRW_MEM", 32'(MemRW_MEM), 32'(m_mem.mw));
    chk("WBSel_MEM", 32'(WBSel_MEM), 32'(m_mem.sel));
    chk("valid_WB", 32'(valid_WB), 32'(m_wb.v));
    chk("inst_WB", inst_WB, m_wb.inst);
    chk("RegWEn_WB", 32'(RegWEn_WB), 32'(m_wb.rw));
    chk("wb_data_WB", wb_data_WB, m_wb.d);
    chk("retire_count", retire_count, m_cnt);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic rw,
                       input logic mw, input WBSel_t sel);
    valid_EX = v; inst_EX = inst; pc_EX = pc; alu_EX = alu;
    rs2data_EX = rs2; RegWEn_EX = rw; MemRW_EX = mw; WBSel_EX = sel;
  endtask

  task automatic idle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, WB_ALU);
  endtask

  typedef struct {
    logic v; logic [31:0] inst, pc, alu, rs2;
    logic rw, mw; WBSel_t sel; logic [31:0] rdata;
    logic e_rw_mem, e_mw_mem; logic [31:0] e_wb; logic e_rw_wb;
  } vec_t;

  vec_t vt[7];
  logic [31:0] held_rs2;

  initial begin
    vt[0] = '{1, ADD, 32'h100, 32'd5, 0, 1, 0, WB_ALU, 0, 1, 0, 32'd5, 1};
    vt[1] = '{1, LW, 32'h104, 32'h200, 0, 1, 0, WB_MEM,
              32'h1234_5678, 1, 0, 32'h1234_5678, 1};
    vt[2] = '{1, JAL, 32'hFFFF_FFFC, 0, 0, 1, 0, WB_PC4, 0, 1, 0, 0, 1};
    vt[3] = '{0, ADD, 32'h10, 32'd77, 32'd9, 1, 1, WB_ALU, 0, 0, 0, 32'd77, 0};
    vt[4] = '{1, SW, 32'h20, 32'd40, 32'hAB, 0, 1, WB_ALU, 0, 0, 1, 32'd40, 0};
    vt[5] = '{1, ADD, 32'h24, 32'd9, 0, 1, 0, WBSel_t'(2'd3), 0, 1, 0, 0, 1};
    vt[6] = '{1, JAL, 32'h1000, 0, 0, 1, 0, WB_PC4, 0, 1, 0, 32'h1004, 1};

    idle();
    rst = 1; stall_MEM = 0; flush_MEM = 0; dmem_rdata = 0;
    m_mem = ins_bub(); m_wb = wb_bub(); m_cnt = 0;
    @(negedge clk);
    tick();
    chk("rst valid_MEM", 32'(valid_MEM), 0);
    chk("rst inst_MEM", inst_MEM, NOP);
    chk("rst inst_WB", inst_WB, NOP);
    chk("rst wb_data", wb_data_WB, 0);
    chk("rst count", retire_count, 0);
    rst = 0;

    // add x3,x1,x2 through both stages, then retire
    drive(1, ADD, 32'h40, 32'd5, 0, 1, 0, WB_ALU);
    tick();
    idle();
    chk("add RegWEn_MEM", 32'(RegWEn_MEM), 1);
    chk("add inst_MEM", inst_MEM, ADD);
    tick();
    chk("add RegWEn_WB", 32'(RegWEn_WB), 1);
    chk("add wb_data", wb_data_WB, 32'd5);
    tick();
    chk("add retired", retire_count, 1);

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].v, vt[i].inst, vt[i].pc, vt[i].alu, vt[i].rs2,
            vt[i].rw, vt[i].mw, vt[i].sel);
      tick();
      idle();
      dmem_rdata = vt[i].rdata;
      chk($sformatf("vec%0d RegWEn_MEM", i), 32'(RegWEn_MEM), 32'(vt[i].e_rw_mem));
      chk($sformatf("vec%0d MemRW_MEM", i), 32'(MemRW_MEM), 32'(vt[i].e_mw_mem));
      tick();
      dmem_rdata = 0;
      chk($sformatf("vec%0d wb_data", i), wb_data_WB, vt[i].e_wb);
      chk($sformatf("vec%0d RegWEn_WB", i), 32'(RegWEn_WB), 32'(vt[i].e_rw_wb));
      chk($sformatf("vec%0d valid_WB", i), 32'(valid_WB), 32'(vt[i].v));
    end

    // load held by two stall cycles
    drive(1, LW, 32'h80, 32'h300, 0, 1, 0, WB_MEM);
    tick();
    idle();
    stall_MEM = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall inst_MEM", inst_MEM, LW);
      chk("stall alu_MEM", alu_MEM, 32'h300);
      chk("stall valid_WB", 32'(valid_WB), 0);
    end
    stall_MEM = 0;
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rdata = 0;
    chk("release wb_data", wb_data_WB, 32'hDEAD_BEEF);
    chk("release valid_WB", 32'(valid_WB), 1);

    // flush wins over stall for a store in EX
    drive(1, SW, 32'h90, 32'h44, 32'h55, 0, 1, WB_ALU);
    flush_MEM = 1; stall_MEM = 1;
    tick();
    flush_MEM = 0; stall_MEM = 0;
    idle();
    chk("flush valid_MEM", 32'(valid_MEM), 0);
    chk("flush MemRW_MEM", 32'(MemRW_MEM), 0);
    chk("flush inst_MEM", inst_MEM, NOP);

    // store held by stall, then reset mid-stall
    drive(1, SW, 32'hA0, 32'h48, 32'hCAFE_0001, 0, 1, WB_ALU);
    tick();
    idle();
    held_rs2 = rs2data_MEM;
    stall_MEM = 1;
    tick();
    chk("held MemRW_MEM", 32'(MemRW_MEM), 1);
    chk("held rs2data", rs2data_MEM, held_rs2);
    rst = 1;
    tick();
    rst = 0; stall_MEM = 0;
    chk("midrst valid_MEM", 32'(valid_MEM), 0);
    chk("midrst MemRW_MEM", 32'(MemRW_MEM), 0);
    chk("midrst inst_MEM", inst_MEM, NOP);
    chk("midrst valid_WB", 32'(valid_WB), 0);
    chk("midrst count", retire_count, 0);

    // counter wrap from all-ones
    drive(1, ADD, 32'hB0, 32'd1, 0, 1, 0, WB_ALU);
    tick();
    idle();
    tick();
    force dut.retire_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    tick();
    chk("wrap count", retire_count, 0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall_MEM = ($urandom_range(0, 3) == 0);
      flush_MEM = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), $urandom, $urandom, $urandom, $urandom,
            1'($urandom), 1'($urandom), WBSel_t'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) pc_EX = 32'hFFFF_FFFC;
      dmem_rdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
